// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg7_reader
// Purpose  : Collects four active-low 7-segment patterns, decodes each to a
//            hex nibble and presents the assembled 16-bit word with an error
//            flag over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic        flush,
  output logic [15:0] word,
  output logic        word_err,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [1:0]  digit_cnt
);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  logic [0:0]  r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_asm;
  logic        r_err_pend;
  logic [15:0] r_word;
  logic        r_word_err;

  logic [3:0]  w_nib;
  logic        w_illegal;
  logic        w_accept;
  logic [15:0] w_asm_next;
  logic        w_err_next;

  // Segment pattern to nibble; unknown patterns decode to 0 and raise illegal
  always_comb begin
    w_nib     = 4'h0;
    w_illegal = 1'b0;
    case (seg_in)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_illegal = 1'b1;
    endcase
  end

  // A flush in COLLECT wins over a pattern presented in the same cycle
  assign w_accept = seg_valid & (r_state == S_COLLECT) & ~flush;

  // First digit lands in bits 15:12; the register is cleared between words,
  // so OR-ing the shifted nibble is enough to place it
  assign w_asm_next = r_asm | ({w_nib, 12'h000} >> {r_cnt, 2'b00});
  assign w_err_next = r_err_pend | w_illegal;

  // Control FSM, word assembly and output word registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_COLLECT;
      r_cnt      <= 2'd0;
      r_asm      <= 16'h0000;
      r_err_pend <= 1'b0;
      r_word     <= 16'h0000;
      r_word_err <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (flush) begin
            r_cnt      <= 2'd0;
            r_asm      <= 16'h0000;
            r_err_pend <= 1'b0;
          end else if (w_accept) begin
            if (r_cnt == 2'd3) begin
              r_word     <= w_asm_next;
              r_word_err <= w_err_next;
              r_cnt      <= 2'd0;
              r_asm      <= 16'h0000;
              r_err_pend <= 1'b0;
              r_state    <= S_HOLD;
            end else begin
              r_asm      <= w_asm_next;
              r_err_pend <= w_err_next;
              r_cnt      <= r_cnt + 2'd1;
            end
          end
        end
        default: begin
          if (word_ready) begin
            r_state <= S_COLLECT;
          end
        end
      endcase
    end
  end

  assign seg_ready  = (r_state == S_COLLECT);
  assign word_valid = (r_state == S_HOLD);
  assign word       = r_word;
  assign word_err   = r_word_err;
  assign digit_cnt  = r_cnt;

endmodule
`default_nettype wire
